uc_elevador: RTL and testbench

Control unit for the elevator manager. It sequences the elevator datapath: it enqueues origin/destination requests into the stop queue, steps the current-floor register up or down one floor per timer period, and holds the door open at each stop. It also pops served stops from the queue. It sits beside the datapath and drives all of its control inputs; its status inputs come from the datapath's comparator, edge detector, timer and queue head.

---
 rtl/uc_elevador_pkg.sv | 33 +++
 rtl/uc_elevador.sv | 136 +++++++++++++
 tb/tb_uc_elevador.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_elevador_pkg.sv
// Shared definitions for the elevator control unit: state codes and queue sizing.
package uc_elevador_pkg;

    localparam int unsigned FILA_PROF    = 16;
    localparam int unsigned LIMIAR_CHEIA = 15;
    localparam int unsigned CONT_W       = $clog2(FILA_PROF + 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ESPERA        = 4'h1,
        GRAVA_ORIGEM  = 4'h2,
        GRAVA_DESTINO = 4'h3,
        DECIDE        = 4'h4,
        PREPARA_MOVE  = 4'h5,
        MOVE          = 4'h6,
        ATUALIZA      = 4'h7,
        PREPARA_PORTA = 4'h8,
        PORTA         = 4'h9,
        REMOVE        = 4'hA
    } estado_t;

    // True when alvo lies strictly between atual and prox along the travel direction.
    function automatic logic entre(input logic [3:0] alvo,
                                   input logic [3:0] atual,
                                   input logic [3:0] prox,
                                   input logic       subindo);
        if (subindo)
            return (alvo > atual) && (alvo < prox);
        else
            return (alvo < atual) && (alvo > prox);
    endfunction

endpackage

// File: rtl/uc_elevador.sv
// Elevator control unit: queues requests, steps the floor register, and runs the door cycle.
module uc_elevador
    import uc_elevador_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       prontoBorda,
    input  logic [3:0] origem,
    input  logic       chegouDestino,
    input  logic       avanca,
    input  logic [3:0] proxParada,
    input  logic [3:0] andarAtual,
    output logic       we_andarAtual,
    output logic       select2,
    output logic       select1,
    output logic       enableRAM,
    output logic       enableTopRAM,
    output logic       shift,
    output logic       zeraT,
    output logic       contaT,
    output logic       porta_aberta,
    output logic       fila_vazia,
    output logic       fila_cheia,
    output logic       pedido_descartado,
    output logic [3:0] db_estado
);

    estado_t             estado, prox_estado;
    estado_t             retorno, retorno_prox;
    logic [CONT_W-1:0]   cont, cont_prox;
    logic                pendente, pendente_prox;
    logic                sobe, sobe_prox;
    logic                topo, topo_prox;
    logic                descartado, descartado_prox;
    logic                cheia;
    logic                aceita;
    logic                pedido;

    assign cheia  = (cont >= CONT_W'(LIMIAR_CHEIA));
    assign pedido = pendente | prontoBorda;
    // MOVE and PORTA only take a request when the timer is not expiring this cycle.
    assign aceita = (estado == ESPERA) || (estado == DECIDE) ||
                    (((estado == MOVE) || (estado == PORTA)) && !avanca);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= INICIAL;
            retorno    <= ESPERA;
            cont       <= '0;
            pendente   <= 1'b0;
            sobe       <= 1'b0;
            topo       <= 1'b0;
            descartado <= 1'b0;
        end else begin
            estado     <= prox_estado;
            retorno    <= retorno_prox;
            cont       <= cont_prox;
            pendente   <= pendente_prox;
            sobe       <= sobe_prox;
            topo       <= topo_prox;
            descartado <= descartado_prox;
        end
    end

    always_comb begin
        prox_estado     = estado;
        retorno_prox    = retorno;
        cont_prox       = cont;
        pendente_prox   = pendente | prontoBorda;
        sobe_prox       = sobe;
        topo_prox       = topo;
        descartado_prox = 1'b0;

        case (estado)
            INICIAL:       prox_estado = ESPERA;
            ESPERA:        prox_estado = ESPERA;
            GRAVA_ORIGEM:  prox_estado = GRAVA_DESTINO;
            GRAVA_DESTINO: begin
                cont_prox   = cont + CONT_W'(2);
                prox_estado = (retorno == ESPERA) ? DECIDE : retorno;
            end
            DECIDE: begin
                if (cont == '0) begin
                    prox_estado = ESPERA;
                end else if (chegouDestino) begin
                    prox_estado = PREPARA_PORTA;
                end else begin
                    sobe_prox   = (proxParada > andarAtual);
                    prox_estado = PREPARA_MOVE;
                end
            end
            PREPARA_MOVE:  prox_estado = MOVE;
            MOVE:          if (avanca) prox_estado = ATUALIZA;
            ATUALIZA:      prox_estado = DECIDE;
            PREPARA_PORTA: prox_estado = PORTA;
            PORTA:         if (avanca) prox_estado = REMOVE;
            REMOVE: begin
                if (cont != '0)
                    cont_prox = cont - CONT_W'(1);
                prox_estado = DECIDE;
            end
            default:       prox_estado = INICIAL;
        endcase

        // A pending request overrides the normal flow of every state that may accept it.
        if (aceita && pedido) begin
            pendente_prox = 1'b0;
            sobe_prox     = sobe;
            if (cheia) begin
                descartado_prox = 1'b1;
                prox_estado     = estado;
            end else begin
                prox_estado  = GRAVA_ORIGEM;
                retorno_prox = estado;
                topo_prox    = (estado == MOVE) && entre(origem, andarAtual, proxParada, sobe);
            end
        end
    end

    always_comb begin
        we_andarAtual     = (estado == ATUALIZA);
        select2           = ((estado == MOVE) || (estado == ATUALIZA)) ? sobe : 1'b0;
        select1           = (estado == GRAVA_ORIGEM);
        enableRAM         = ((estado == GRAVA_ORIGEM) && !topo) || (estado == GRAVA_DESTINO);
        enableTopRAM      = (estado == GRAVA_ORIGEM) && topo;
        shift             = (estado == REMOVE);
        zeraT             = (estado == PREPARA_MOVE) || (estado == PREPARA_PORTA);
        contaT            = (estado == MOVE) || (estado == PORTA);
        porta_aberta      = (estado == PREPARA_PORTA) || (estado == PORTA);
        fila_vazia        = (cont == '0);
        fila_cheia        = cheia;
        pedido_descartado = descartado;
        db_estado         = estado;
    end

endmodule

// File: tb/tb_uc_elevador.sv
// Directed bench for uc_elevador with a behavioural datapath (floor register, queue, timer).
module tb_uc_elevador;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       prontoBorda = 1'b0;
    logic [3:0] origem = 4'd0;
    logic [3:0] destino = 4'd0;
    logic       chegouDestino;
    logic       avanca;
    logic [3:0] proxParada;
    logic [3:0] andarAtual;
    logic       we_andarAtual, select2, select1, enableRAM, enableTopRAM, shift;
    logic       zeraT, contaT, porta_aberta, fila_vazia, fila_cheia, pedido_descartado;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    uc_elevador dut (
        .clock(clock), .reset(reset), .prontoBorda(prontoBorda), .origem(origem),
        .chegouDestino(chegouDestino), .avanca(avanca), .proxParada(proxParada),
        .andarAtual(andarAtual), .we_andarAtual(we_andarAtual), .select2(select2),
        .select1(select1), .enableRAM(enableRAM), .enableTopRAM(enableTopRAM),
        .shift(shift), .zeraT(zeraT), .contaT(contaT), .porta_aberta(porta_aberta),
        .fila_vazia(fila_vazia), .fila_cheia(fila_cheia),
        .pedido_descartado(pedido_descartado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model driven by the controller outputs.
    logic [3:0]  mem [16];
    logic [4:0]  qn;
    logic [11:0] timer;
    logic [3:0]  andar;
    logic [3:0]  andar_ini = 4'd0;
    logic [3:0]  dado;

    assign dado          = select1 ? origem : destino;
    assign andarAtual    = andar;
    assign proxParada    = mem[0];
    assign chegouDestino = (qn != 5'd0) && (mem[0] == andar);
    assign avanca        = (timer == 12'd1999);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            qn    <= '0;
            timer <= '0;
            andar <= andar_ini;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (zeraT) timer <= '0;
            else if (contaT) timer <= timer + 12'd1;
            if (we_andarAtual) andar <= select2 ? andar + 4'd1 : andar - 4'd1;
            if (enableTopRAM) begin
                for (int i = 1; i < 16; i++) mem[i] <= mem[i-1];
                mem[0] <= dado;
                qn <= qn + 5'd1;
            end else if (enableRAM) begin
                if (qn < 5'd16) mem[qn[3:0]] <= dado;
                qn <= qn + 5'd1;
            end else if (shift) begin
                for (int i = 0; i < 15; i++) mem[i] <= mem[i+1];
                mem[15] <= '0;
                if (qn != 5'd0) qn <= qn - 5'd1;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [3:0] f);
        andar_ini = f;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_req(input logic [3:0] o, input logic [3:0] d);
        origem = o;
        destino = d;
        prontoBorda = 1'b1;
        tick();
        prontoBorda = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int max, output bit ok);
        int n = 0;
        while (db_estado !== s && n < max) begin
            tick();
            n++;
        end
        ok = (db_estado === s);
    endtask

    // Runs until PORTA, counting floor steps and timing the first full step.
    task automatic run_travel(input int max, output int steps, output int ups,
                              output int downs, output int step_len, output bit ok);
        int n = 0;
        int start = -1;
        steps = 0; ups = 0; downs = 0; step_len = -1;
        while (db_estado !== 4'h9 && n < max) begin
            if (db_estado === 4'h5 && start < 0) start = n;
            if (we_andarAtual === 1'b1) begin
                if (steps == 0 && start >= 0) step_len = n - start + 1;
                steps++;
                if (select2) ups++; else downs++;
            end
            tick();
            n++;
        end
        ok = (db_estado === 4'h9);
    endtask

    task automatic count_door(input int max, output int open, output bit ok);
        int n = 0;
        open = 0;
        while (db_estado !== 4'hA && n < max) begin
            if (porta_aberta === 1'b1) open++;
            tick();
            n++;
        end
        ok = (db_estado === 4'hA);
    endtask

    task automatic test_reset();
        logic [10:0] ctl;
        andar_ini = 4'd0;
        reset = 1'b1;
        tick();
        tick();
        ctl = {we_andarAtual, select2, select1, enableRAM, enableTopRAM, shift,
               zeraT, contaT, porta_aberta, fila_cheia, pedido_descartado};
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_state: got %0h expected 0", db_estado); end
        checks++;
        if (ctl !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", ctl); end
        checks++;
        if (fila_vazia !== 1'b1) begin errors++; $display("FAIL reset_vazia: got %b expected 1", fila_vazia); end
        reset = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'h1) begin errors++; $display("FAIL reset_to_espera: got %0h expected 1", db_estado); end
    endtask

    task automatic test_idle_to_door();
        int open, steps, ups, downs, len;
        bit ok;
        do_reset(4'd0);
        send_req(4'd0, 4'd3);
        checks++;
        if (db_estado !== 4'h2 || select1 !== 1'b1 || enableRAM !== 1'b1 || enableTopRAM !== 1'b0)
            begin errors++; $display("FAIL idle_grava_origem: state %0h sel1 %b ram %b top %b expected 2 1 1 0", db_estado, select1, enableRAM, enableTopRAM); end
        checks++;
        if (zeraT !== 1'b0 || contaT !== 1'b0) begin errors++; $display("FAIL idle_timer_frozen: zeraT %b contaT %b expected 0 0", zeraT, contaT); end
        tick();
        checks++;
        if (db_estado !== 4'h3 || select1 !== 1'b0 || enableRAM !== 1'b1)
            begin errors++; $display("FAIL idle_grava_destino: state %0h sel1 %b ram %b expected 3 0 1", db_estado, select1, enableRAM); end
        tick();
        checks++;
        if (db_estado !== 4'h4 || fila_vazia !== 1'b0) begin errors++; $display("FAIL idle_decide: state %0h vazia %b expected 4 0", db_estado, fila_vazia); end
        tick();
        checks++;
        if (db_estado !== 4'h8 || zeraT !== 1'b1 || porta_aberta !== 1'b1)
            begin errors++; $display("FAIL idle_prepara_porta: state %0h zeraT %b porta %b expected 8 1 1", db_estado, zeraT, porta_aberta); end
        count_door(5000, open, ok);
        checks++;
        if (!ok || open != 2001) begin errors++; $display("FAIL idle_door_len: got %0d expected 2001", open); end
        checks++;
        if (shift !== 1'b1) begin errors++; $display("FAIL idle_shift: got %b expected 1", shift); end
        tick();
        checks++;
        if (qn !== 5'd1 || fila_vazia !== 1'b0 || db_estado !== 4'h4)
            begin errors++; $display("FAIL idle_after_pop: qn %0d vazia %b state %0h expected 1 0 4", qn, fila_vazia, db_estado); end
        run_travel(10000, steps, ups, downs, len, ok);
        checks++;
        if (!ok || steps != 3 || ups != 3) begin errors++; $display("FAIL idle_up_steps: steps %0d ups %0d expected 3 3", steps, ups); end
        checks++;
        if (len != 2002) begin errors++; $display("FAIL idle_step_len: got %0d expected 2002", len); end
        checks++;
        if (andarAtual !== 4'd3) begin errors++; $display("FAIL idle_floor3: got %0d expected 3", andarAtual); end
        wait_state(4'hA, 5000, ok);
        tick();
        checks++;
        if (!ok || fila_vazia !== 1'b1) begin errors++; $display("FAIL idle_empty: got %b expected 1", fila_vazia); end
        tick();
        checks++;
        if (db_estado !== 4'h1) begin errors++; $display("FAIL idle_back_espera: got %0h expected 1", db_estado); end
    endtask

    task automatic test_downward();
        int steps, ups, downs, len;
        bit ok;
        do_reset(4'd5);
        send_req(4'd2, 4'd0);
        run_travel(10000, steps, ups, downs, len, ok);
        checks++;
        if (!ok || steps != 3 || downs != 3 || andarAtual !== 4'd2)
            begin errors++; $display("FAIL down_first_leg: steps %0d downs %0d floor %0d expected 3 3 2", steps, downs, andarAtual); end
        wait_state(4'hA, 5000, ok);
        tick();
        run_travel(10000, steps, ups, downs, len, ok);
        checks++;
        if (!ok || steps != 2 || downs != 2 || andarAtual !== 4'd0)
            begin errors++; $display("FAIL down_second_leg: steps %0d downs %0d floor %0d expected 2 2 0", steps, downs, andarAtual); end
        wait_state(4'hA, 5000, ok);
        tick();
        checks++;
        if (!ok || fila_vazia !== 1'b1) begin errors++; $display("FAIL down_empty: got %b expected 1", fila_vazia); end
    endtask

    task automatic test_head_insert();
        int steps, ups, downs, len;
        logic [11:0] t0;
        bit ok;
        do_reset(4'd1);
        send_req(4'd1, 4'd6);
        wait_state(4'h6, 6000, ok);
        repeat (100) tick();
        t0 = timer;
        send_req(4'd4, 4'd7);
        checks++;
        if (!ok || db_estado !== 4'h2 || enableTopRAM !== 1'b1 || enableRAM !== 1'b0)
            begin errors++; $display("FAIL head_top_write: state %0h top %b ram %b expected 2 1 0", db_estado, enableTopRAM, enableRAM); end
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h6 || timer !== t0 + 12'd1)
            begin errors++; $display("FAIL head_resume_move: state %0h timer %0d expected 6 %0d", db_estado, timer, t0 + 12'd1); end
        checks++;
        if (proxParada !== 4'd4) begin errors++; $display("FAIL head_new_head: got %0d expected 4", proxParada); end
        run_travel(10000, steps, ups, downs, len, ok);
        checks++;
        if (!ok || andarAtual !== 4'd4 || ups != 3)
            begin errors++; $display("FAIL head_door_at4: floor %0d ups %0d expected 4 3", andarAtual, ups); end
    endtask

    task automatic test_full_queue();
        bit ok;
        do_reset(4'd0);
        send_req(4'd0, 4'd9);
        wait_state(4'hA, 5000, ok);
        wait_state(4'h6, 100, ok);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                checks++;
                if (fila_cheia !== 1'b0) begin errors++; $display("FAIL full_not_yet: got %b expected 0", fila_cheia); end
            end
            send_req(4'd10, 4'd10);
            tick();
            tick();
        end
        checks++;
        if (!ok || fila_cheia !== 1'b1 || qn !== 5'd15 || db_estado !== 4'h6)
            begin errors++; $display("FAIL full_reached: cheia %b qn %0d state %0h expected 1 15 6", fila_cheia, qn, db_estado); end
        send_req(4'd11, 4'd11);
        checks++;
        if (pedido_descartado !== 1'b1 || enableRAM !== 1'b0 || db_estado !== 4'h6)
            begin errors++; $display("FAIL full_drop_pulse: desc %b ram %b state %0h expected 1 0 6", pedido_descartado, enableRAM, db_estado); end
        tick();
        checks++;
        if (pedido_descartado !== 1'b0 || enableRAM !== 1'b0 || qn !== 5'd15 || fila_cheia !== 1'b1)
            begin errors++; $display("FAIL full_drop_after: desc %b ram %b qn %0d cheia %b expected 0 0 15 1", pedido_descartado, enableRAM, qn, fila_cheia); end
    endtask

    task automatic test_collision();
        int n = 0;
        do_reset(4'd0);
        send_req(4'd2, 4'd2);
        while (!(db_estado === 4'h6 && avanca === 1'b1) && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL coll_timeout: got %0d cycles expected < 5000", n); end
        origem = 4'd5;
        destino = 4'd5;
        prontoBorda = 1'b1;
        tick();
        prontoBorda = 1'b0;
        checks++;
        if (db_estado !== 4'h7 || we_andarAtual !== 1'b1) begin errors++; $display("FAIL coll_atualiza: state %0h we %b expected 7 1", db_estado, we_andarAtual); end
        tick();
        checks++;
        if (db_estado !== 4'h4) begin errors++; $display("FAIL coll_decide: got %0h expected 4", db_estado); end
        tick();
        checks++;
        if (db_estado !== 4'h2 || enableRAM !== 1'b1 || enableTopRAM !== 1'b0)
            begin errors++; $display("FAIL coll_grava: state %0h ram %b top %b expected 2 1 0", db_estado, enableRAM, enableTopRAM); end
    endtask

    task automatic test_reset_in_porta();
        bit ok;
        do_reset(4'd0);
        send_req(4'd0, 4'd1);
        wait_state(4'h9, 100, ok);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || db_estado !== 4'h0 || porta_aberta !== 1'b0 || contaT !== 1'b0 || fila_vazia !== 1'b1)
            begin errors++; $display("FAIL rst_porta: state %0h porta %b conta %b vazia %b expected 0 0 0 1", db_estado, porta_aberta, contaT, fila_vazia); end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'h1) begin errors++; $display("FAIL rst_porta_espera: got %0h expected 1", db_estado); end
    endtask

    initial begin
        test_reset();
        test_idle_to_door();
        test_downward();
        test_head_insert();
        test_full_queue();
        test_collision();
        test_reset_in_porta();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
